// File: rtl/pipe_ctrl.sv
// Pipeline hazard/sequencing controller: hold/flush/redirect generation, pending-jump buffer, stall counter.
// Optional MC watchdog enabled by defining PIPE_CTRL_MC_TIMEOUT_EN.
module pipe_ctrl #(
    parameter int MC_TIMEOUT  = 64,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic                   id_rs1_ren,
    input  logic                   id_rs2_ren,
    input  logic [4:0]             ex_rd_addr,
    input  logic                   ex_rd_w_en,
    input  logic                   ex_is_load,
    input  logic                   ex_jump_en,
    input  logic [31:0]            ex_jump_addr,
    input  logic                   ex_mc_start,
    input  logic                   ex_mc_done,
    input  logic                   mem_stall_req,
    output logic                   pc_hold,
    output logic                   if_id_hold,
    output logic                   id_ex_hold,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   jump_en_o,
    output logic [31:0]            jump_addr_o,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   mc_timeout_o
);

    typedef enum logic [0:0] {RUN, MC_BUSY} state_t;

    state_t      state, state_nxt;
    logic        jump_pend, jump_pend_nxt;
    logic [31:0] jump_addr_q, jump_addr_nxt;
    logic        load_use;
    logic        mc_expire;

    assign load_use = ex_is_load & ex_rd_w_en & (ex_rd_addr != 5'd0) &
                      ((id_rs1_ren & (id_rs1_addr == ex_rd_addr)) |
                       (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));

`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    localparam int MC_CNT_W = ($clog2(MC_TIMEOUT) + 1 > 8) ? $clog2(MC_TIMEOUT) + 1 : 8;

    logic [MC_CNT_W-1:0] mc_cnt;
    logic                mc_timeout_q;

    // Held at zero in RUN, so it is already cleared on entry to MC_BUSY.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mc_cnt       <= '0;
            mc_timeout_q <= 1'b0;
        end else begin
            if (state == RUN)
                mc_cnt <= '0;
            else if (!mem_stall_req && !ex_mc_done)
                mc_cnt <= mc_cnt + MC_CNT_W'(1);
            if (mc_expire)
                mc_timeout_q <= 1'b1;
        end
    end

    assign mc_expire    = (state == MC_BUSY) && !mem_stall_req && !ex_mc_done &&
                          (mc_cnt == MC_CNT_W'(MC_TIMEOUT - 1));
    assign mc_timeout_o = mc_timeout_q;
`else
    logic unused_mc_timeout;
    assign unused_mc_timeout = (MC_TIMEOUT > 0);
    assign mc_expire         = 1'b0;
    assign mc_timeout_o      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            jump_pend   <= 1'b0;
            jump_addr_q <= '0;
        end else begin
            state       <= state_nxt;
            jump_pend   <= jump_pend_nxt;
            jump_addr_q <= jump_addr_nxt;
        end
    end

    always_comb begin
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        id_ex_hold    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        jump_en_o     = 1'b0;
        jump_addr_o   = jump_addr_q;
        state_nxt     = state;
        jump_pend_nxt = jump_pend;
        jump_addr_nxt = jump_addr_q;

        if (mem_stall_req) begin
            pc_hold    = 1'b1;
            if_id_hold = 1'b1;
            id_ex_hold = 1'b1;
            if (ex_jump_en) begin
                jump_pend_nxt = 1'b1;
                jump_addr_nxt = ex_jump_addr;
            end
        end else if (state == MC_BUSY) begin
            if (ex_jump_en) begin
                jump_pend_nxt = 1'b1;
                jump_addr_nxt = ex_jump_addr;
            end
            if (ex_mc_done || mc_expire) begin
                state_nxt = RUN;
            end else begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                id_ex_hold = 1'b1;
            end
        end else if (ex_jump_en || jump_pend) begin
            // A buffered jump is older than any new EX jump, so it redirects first.
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_pend ? jump_addr_q : ex_jump_addr;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            jump_pend_nxt = 1'b0;
        end else if (ex_mc_start) begin
            if (!ex_mc_done) begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                id_ex_hold = 1'b1;
                state_nxt  = MC_BUSY;
            end
        end else if (load_use) begin
            pc_hold     = 1'b1;
            if_id_hold  = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (pc_hold && (stall_cnt != '1))
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected outputs queued per driven cycle, popped at the following negedge.
// Narrow stall counter so saturation is reached within the run.
module tb_pipe_ctrl;

    localparam int SW = 4;
`ifdef PIPE_CTRL_MC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_rs1_ren, id_rs2_ren, ex_rd_w_en, ex_is_load;
    logic          ex_jump_en, ex_mc_start, ex_mc_done, mem_stall_req;
    logic [31:0]   ex_jump_addr;
    logic          pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, jump_en_o;
    logic [31:0]   jump_addr_o;
    logic [SW-1:0] stall_cnt;
    logic          mc_timeout_o;

    pipe_ctrl #(.MC_TIMEOUT(8), .STALL_CNT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .ex_rd_addr(ex_rd_addr), .ex_rd_w_en(ex_rd_w_en), .ex_is_load(ex_is_load),
        .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .mem_stall_req(mem_stall_req),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .id_ex_hold(id_ex_hold),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
        .stall_cnt(stall_cnt), .mc_timeout_o(mc_timeout_o)
    );

    always #5 clk = ~clk;

    // ctl = {pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, jump_en_o}
    typedef struct packed {
        logic [5:0]  ctl;
        logic [31:0] addr;
        logic [31:0] scnt;
        logic        mto;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned exp_scnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    endtask

    task automatic push(input logic [5:0] ctl, input logic [31:0] addr, input logic mto);
        exp_t e;
        e.ctl  = ctl;
        e.addr = addr;
        e.scnt = exp_scnt;
        e.mto  = mto;
        exp_q.push_back(e);
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        @(negedge clk);
        check({tag, "_sb"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_ctl"}, 64'({pc_hold, if_id_hold, id_ex_hold, if_id_flush, id_ex_flush, jump_en_o}), 64'(e.ctl));
            check({tag, "_addr"}, 64'(jump_addr_o), 64'(e.addr));
            check({tag, "_scnt"}, 64'(stall_cnt), 64'(e.scnt));
            check({tag, "_mto"}, 64'(mc_timeout_o), 64'(e.mto));
            check({tag, "_hf"}, 64'((if_id_hold & if_id_flush) | (id_ex_hold & id_ex_flush)), 64'd0);
            if (!rst_n) exp_scnt = 0;
            else if (e.ctl[5] && exp_scnt < (2**SW - 1)) exp_scnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0;
        id_rs1_ren = 0; id_rs2_ren = 0; ex_rd_w_en = 0; ex_is_load = 0;
        ex_jump_en = 0; ex_jump_addr = '0; ex_mc_start = 0; ex_mc_done = 0; mem_stall_req = 0;
    endtask

    task automatic load_use_in(input logic [4:0] rd, input logic [4:0] rs1);
        ex_is_load = 1; ex_rd_w_en = 1; ex_rd_addr = rd;
        id_rs1_ren = 1; id_rs1_addr = rs1;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        @(posedge clk); #1;
        push(6'b000000, 32'h0, 0); cycle("reset");
        rst_n = 1;
        push(6'b000000, 32'h0, 0); cycle("idle");

        // load-use on rs1, rd=0 suppression, rs2 match, rs2 not read
        load_use_in(5'd5, 5'd5);
        push(6'b110010, 32'h0, 0); cycle("lu_rs1");
        load_use_in(5'd0, 5'd0);
        push(6'b000000, 32'h0, 0); cycle("lu_rd0");
        idle_in();
        ex_is_load = 1; ex_rd_w_en = 1; ex_rd_addr = 5'd7; id_rs2_ren = 1; id_rs2_addr = 5'd7;
        push(6'b110010, 32'h0, 0); cycle("lu_rs2");
        id_rs2_ren = 0;
        push(6'b000000, 32'h0, 0); cycle("lu_noren");
        idle_in();

        // jump suppresses a same-cycle load-use
        load_use_in(5'd5, 5'd5);
        ex_jump_en = 1; ex_jump_addr = 32'h0000_0100;
        push(6'b000111, 32'h100, 0); cycle("jump");
        idle_in();
        push(6'b000000, 32'h0, 0); cycle("post_jump");

        // jump buffered across a 3-cycle memory stall
        mem_stall_req = 1; ex_jump_en = 1; ex_jump_addr = 32'h200;
        push(6'b111000, 32'h0, 0); cycle("mst0");
        ex_jump_en = 0; ex_jump_addr = 32'h999;
        push(6'b111000, 32'h200, 0); cycle("mst1");
        push(6'b111000, 32'h200, 0); cycle("mst2");
        mem_stall_req = 0; ex_jump_addr = 32'h300;
        push(6'b000111, 32'h200, 0); cycle("pend_jump");
        idle_in();
        push(6'b000000, 32'h200, 0); cycle("pend_clr");

        // multi-cycle op t0..t5 with a jump captured mid-op
        ex_mc_start = 1;
        push(6'b111000, 32'h200, 0); cycle("mc_t0");
        ex_mc_start = 0;
        push(6'b111000, 32'h200, 0); cycle("mc_t1");
        ex_jump_en = 1; ex_jump_addr = 32'h400;
        push(6'b111000, 32'h200, 0); cycle("mc_t2");
        ex_jump_en = 0; ex_jump_addr = 32'h0;
        push(6'b111000, 32'h400, 0); cycle("mc_t3");
        push(6'b111000, 32'h400, 0); cycle("mc_t4");
        ex_mc_done = 1;
        push(6'b000000, 32'h400, 0); cycle("mc_t5");
        ex_mc_done = 0;
        push(6'b000111, 32'h400, 0); cycle("mc_t6_jump");
        load_use_in(5'd9, 5'd9);
        push(6'b110010, 32'h400, 0); cycle("mc_t7_lu");
        idle_in();

        // start+done same cycle: no hold, stays in RUN
        ex_mc_start = 1; ex_mc_done = 1;
        push(6'b000000, 32'h400, 0); cycle("mc_fast");
        idle_in();
        load_use_in(5'd3, 5'd3);
        push(6'b110010, 32'h400, 0); cycle("mc_fast_run");
        idle_in();

        // done arriving under a mem stall is not consumed
        ex_mc_start = 1;
        push(6'b111000, 32'h400, 0); cycle("mcs_t0");
        ex_mc_start = 0; mem_stall_req = 1; ex_mc_done = 1;
        push(6'b111000, 32'h400, 0); cycle("mcs_stall");
        mem_stall_req = 0;
        push(6'b000000, 32'h400, 0); cycle("mcs_done");
        idle_in();
        load_use_in(5'd4, 5'd4);
        push(6'b110010, 32'h400, 0); cycle("mcs_run");
        idle_in();

        // never-done op: watchdog releases after 8 cycles when enabled, else holds persist
        ex_mc_start = 1;
        for (int i = 0; i < 12; i++) begin
            push(((!TO_EN) || i < 8) ? 6'b111000 : 6'b000000, 32'h400, TO_EN && i >= 9);
            cycle("mc_to");
            ex_mc_start = 0;
        end

        // reset while busy with a pending jump discards both
        ex_mc_start = 1;
        push(6'b111000, 32'h400, TO_EN); cycle("rst_mc");
        ex_mc_start = 0; ex_jump_en = 1; ex_jump_addr = 32'h500;
        push(6'b111000, 32'h400, TO_EN); cycle("rst_jcap");
        idle_in();
        rst_n = 0;
        push(6'b111000, 32'h500, TO_EN); cycle("rst_assert");
        rst_n = 1;
        push(6'b000000, 32'h0, 0); cycle("rst_after");
        push(6'b000000, 32'h0, 0); cycle("rst_noredir");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
